// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
//   Bundle between the hazard sources / fetch datapath and fetch_ctrl.
//   slave  : the fetch controller (consumes hazard info, drives controls)
//   master : the surrounding pipeline (drives hazard info, consumes controls)
// Signals
//   br_taken_i, br_target_i          EX redirect request and target
//   ld_ex_i, rd_ex_i                 EX load flag and destination register
//   rs1_id_i, rs2_id_i               ID source registers
//   rs1_use_i, rs2_use_i             ID source-use flags
//   imem_valid_i                     instruction memory data valid for current PC
//   pc_sel_o, pc_target_o            PC mux select / redirect target
//   enable_pc_o, enable_ifid_o       PC and IF/ID register enables
//   flush_ifid_o, flush_idex_o       IF/ID clear, ID/EX bubble insert
//   stall_cnt_o, flush_cnt_o         performance counters
// ---------------------------------------------------------------------------
interface fetch_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             br_taken_i;
  logic [XLEN-1:0]  br_target_i;
  logic             ld_ex_i;
  logic [4:0]       rd_ex_i;
  logic [4:0]       rs1_id_i;
  logic [4:0]       rs2_id_i;
  logic             rs1_use_i;
  logic             rs2_use_i;
  logic             imem_valid_i;
  logic             pc_sel_o;
  logic [XLEN-1:0]  pc_target_o;
  logic             enable_pc_o;
  logic             enable_ifid_o;
  logic             flush_ifid_o;
  logic             flush_idex_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport slave (
    input  br_taken_i, br_target_i, ld_ex_i, rd_ex_i, rs1_id_i, rs2_id_i,
           rs1_use_i, rs2_use_i, imem_valid_i,
    output pc_sel_o, pc_target_o, enable_pc_o, enable_ifid_o, flush_ifid_o,
           flush_idex_o, stall_cnt_o, flush_cnt_o
  );

  modport master (
    output br_taken_i, br_target_i, ld_ex_i, rd_ex_i, rs1_id_i, rs2_id_i,
           rs1_use_i, rs2_use_i, imem_valid_i,
    input  pc_sel_o, pc_target_o, enable_pc_o, enable_ifid_o, flush_ifid_o,
           flush_idex_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Sequencing controller for the fetch stage and the IF/ID, ID/EX pipeline
//   registers. Resolves EX redirects, load-use stalls and a multi-cycle
//   instruction memory. Outputs are Mealy: every decision takes effect at the
//   next clock edge.
// Ports
//   clk_i   clock, rising edge
//   rst_ni  asynchronous reset, active-low; forces all controls to 0
//   bus     fetch_ctrl_if.slave (hazard inputs, fetch/pipeline controls,
//           performance counters)
// Configuration
//   FETCH_CTRL_PERF_EN  build the saturating stall/redirect counters;
//                       when undefined both counter outputs are tied to 0.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  fetch_ctrl_if.slave   bus
);

  // RUN: fetch delivered each cycle; WAIT: fetch outstanding;
  // DISCARD: redirect queued behind a fetch that cannot be cancelled.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e          state_d, state_q;
  logic [XLEN-1:0] pend_tgt_d, pend_tgt_q;

  logic            pc_sel, enable_pc, enable_ifid, flush_ifid, flush_idex;
  logic [XLEN-1:0] pc_target;
  logic            lu;

  // Load-use hazard: ID reads the register a load in EX is about to write.
  assign lu = bus.ld_ex_i && (bus.rd_ex_i != 5'd0) &&
              ((bus.rs1_use_i && (bus.rd_ex_i == bus.rs1_id_i)) ||
               (bus.rs2_use_i && (bus.rd_ex_i == bus.rs2_id_i)));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d     = state_q;
    pend_tgt_d  = pend_tgt_q;
    pc_sel      = 1'b0;
    enable_pc   = 1'b1;
    enable_ifid = 1'b1;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    pc_target   = bus.br_target_i;

    unique case (state_q)
      RUN, WAIT: begin
        if (bus.br_taken_i) begin
          pc_sel     = 1'b1;
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
          // A fetch still in flight cannot be cancelled: park the target
          // until memory answers, then drop the stale word.
          if (state_q == WAIT && !bus.imem_valid_i) begin
            state_d    = DISCARD;
            pend_tgt_d = bus.br_target_i;
          end else begin
            state_d = RUN;
          end
        end else if (lu) begin
          // Hold PC and IF/ID, bubble into EX; next cycle EX holds the
          // bubble so the hazard clears after exactly one cycle.
          enable_pc   = 1'b0;
          enable_ifid = 1'b0;
          flush_idex  = 1'b1;
        end else if (!bus.imem_valid_i) begin
          enable_pc  = 1'b0;
          flush_ifid = 1'b1;
          state_d    = WAIT;
        end else begin
          state_d = RUN;
        end
      end

      DISCARD: begin
        // EX only holds bubbles here, so br_taken_i and lu cannot occur.
        flush_ifid = 1'b1;
        if (bus.imem_valid_i) begin
          pc_sel    = 1'b1;
          pc_target = pend_tgt_q;
          state_d   = RUN;
        end else begin
          enable_pc = 1'b0;
        end
      end

      default: state_d = RUN;
    endcase
  end

  // Controls are forced low while reset is asserted, independent of state.
  assign bus.pc_sel_o      = rst_ni & pc_sel;
  assign bus.enable_pc_o   = rst_ni & enable_pc;
  assign bus.enable_ifid_o = rst_ni & enable_ifid;
  assign bus.flush_ifid_o  = rst_ni & flush_ifid;
  assign bus.flush_idex_o  = rst_ni & flush_idex;
  assign bus.pc_target_o   = rst_ni ? pc_target : '0;

  // NOTE: state registers use non-blocking assignments so all flops sample
  // their inputs at the same edge regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  // Saturating counters: stall = PC held without a redirect, flush = redirect applied.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!enable_pc && !pc_sel && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (pc_sel && (flush_cnt_q != '1))                flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt_o = stall_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
`else
  localparam logic [CNT_W-1:0] CntZero = '0;
  assign bus.stall_cnt_o = CntZero;
  assign bus.flush_cnt_o = CntZero;
`endif

endmodule
